// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: default sizing,
// handler-vector arithmetic and the controller state encoding.
package interrupt_controller_pkg;

    localparam int         NUM_IRQ_DEF    = 4;
    localparam logic [7:0] VEC_BASE_DEF   = 8'hF0;
    localparam int         VEC_STRIDE_DEF = 4;

    // Controller phases of one interrupt delivery
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    // Index width that stays legal for a single request line
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Handler address for a line index, wrapped into the 8-bit address space
    function automatic logic [7:0] vec_addr(input logic [7:0] base,
                                            input int         stride,
                                            input int         idx);
        return 8'(int'(base) + idx * stride);
    endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: lowest-numbered active request wins.
module irq_priority_encoder
    import interrupt_controller_pkg::*;
#(
    parameter int NUM_IRQ = NUM_IRQ_DEF,
    parameter int IDX_W   = idx_width(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] req_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Vectored interrupt controller: edge-detected request lines, a mask
// register, fixed-priority arbitration and a one-request-at-a-time
// IDLE -> ASSERT -> SERVICE delivery sequence closed by rti.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int         NUM_IRQ    = NUM_IRQ_DEF,
    parameter logic [7:0] VEC_BASE   = VEC_BASE_DEF,
    parameter int         VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               rti,
    output logic               interrupt,
    output logic [7:0]         int_addr,
    output logic               busy,
    output logic [NUM_IRQ-1:0] pending
);

    localparam int IDX_W = idx_width(NUM_IRQ);

    irq_state_e         state_q, state_d;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [7:0]         int_addr_q, int_addr_d;
    logic               armed_q;

    logic [NUM_IRQ-1:0] irq_edge;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] grant;
    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;
    logic               take;

    // armed_q stays low for the first edge after reset so a line that is
    // already high at release is absorbed into irq_q rather than seen as new
    assign irq_edge = irq & ~irq_q & {NUM_IRQ{armed_q}};
    assign eligible = pending_q & mask_q;

    irq_priority_encoder #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (IDX_W)
    ) u_prio (
        .req_i   (eligible),
        .valid_o (win_valid),
        .idx_o   (win_idx)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; rti only matters while a handler is in service
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (win_valid) state_d = ST_ASSERT;
            ST_ASSERT:  state_d = ST_SERVICE;
            ST_SERVICE: if (rti) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs and the grant strobe for the winning line
    always_comb begin
        interrupt = 1'b0;
        busy      = 1'b0;
        take      = 1'b0;
        grant     = '0;
        case (state_q)
            ST_IDLE: begin
                take  = win_valid;
                grant = win_valid ? (NUM_IRQ'(1) << win_idx) : '0;
            end
            ST_ASSERT: begin
                interrupt = 1'b1;
                busy      = 1'b1;
            end
            ST_SERVICE: begin
                busy = 1'b1;
            end
            default: begin
                interrupt = 1'b0;
            end
        endcase
    end

    // Pending/mask/vector next values; a fresh edge beats a same-cycle grant
    always_comb begin
        pending_d  = (pending_q & ~grant) | irq_edge;
        mask_d     = mask_we ? mask_wdata : mask_q;
        int_addr_d = take ? vec_addr(VEC_BASE, VEC_STRIDE, int'(win_idx))
                          : int_addr_q;
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q      <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            int_addr_q <= '0;
            armed_q    <= 1'b0;
        end else begin
            irq_q      <= irq;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            int_addr_q <= int_addr_d;
            armed_q    <= 1'b1;
        end
    end

    assign int_addr = int_addr_q;
    assign pending  = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios plus a
// randomized phase, all compared against a behavioural delivery model.
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic       rti;
    logic       interrupt;
    logic [7:0] int_addr;
    logic       busy;
    logic [3:0] pending;

    int tests = 0;
    int fails = 0;
    int n_int = 0;

    // Behavioural model: which line is in service (-1 none) and how many
    // edges it has been in service for, plus pending/mask bit sets
    bit [3:0] m_pend;
    bit [3:0] m_mask;
    bit [3:0] m_prev;
    bit       m_armed;
    int       m_cur;
    int       m_age;
    bit [7:0] m_addr;

    interrupt_controller dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .rti        (rti),
        .interrupt  (interrupt),
        .int_addr   (int_addr),
        .busy       (busy),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("interrupt", 32'(interrupt), 32'(m_cur >= 0 && m_age == 0));
        chk("busy",      32'(busy),      32'(m_cur >= 0));
        chk("int_addr",  32'(int_addr),  32'(m_addr));
        chk("pending",   32'(pending),   32'(m_pend));
    endtask

    task automatic model_reset();
        m_pend  = '0;
        m_mask  = '0;
        m_prev  = '0;
        m_armed = 1'b0;
        m_cur   = -1;
        m_age   = 0;
        m_addr  = '0;
    endtask

    // One clock: drive inputs, advance the model across the edge, compare
    task automatic step(input logic [3:0] irq_v, input logic we_v,
                        input logic [3:0] wd_v, input logic rti_v);
        bit [3:0] edges;
        int       win;
        irq        = irq_v;
        mask_we    = we_v;
        mask_wdata = wd_v;
        rti        = rti_v;
        @(posedge clk);
        for (int i = 0; i < 4; i++) edges[i] = m_armed && irq_v[i] && !m_prev[i];
        if (m_cur < 0) begin
            win = -1;
            for (int i = 3; i >= 0; i--) if (m_pend[i] && m_mask[i]) win = i;
            if (win >= 0) begin
                m_cur        = win;
                m_age        = 0;
                m_addr       = 8'(8'hF0 + win * 4);
                m_pend[win]  = 1'b0;
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (rti_v) begin
            m_cur = -1;
        end
        m_pend  = m_pend | edges;
        if (we_v) m_mask = wd_v;
        m_prev  = irq_v;
        m_armed = 1'b1;
        #1;
        if (interrupt === 1'b1) n_int++;
        check_model();
    endtask

    task automatic do_reset();
        mask_we = 1'b0;
        rti     = 1'b0;
        reset   = 1'b1;
        #1;
        model_reset();
        chk("rst_interrupt", 32'(interrupt), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_pending",   32'(pending),   32'd0);
        chk("rst_int_addr",  32'(int_addr),  32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] cur_irq;
        logic [31:0] r;
        reset      = 1'b0;
        irq        = '0;
        mask_we    = 1'b0;
        mask_wdata = '0;
        rti        = 1'b0;
        model_reset();
        #2;
        do_reset();

        // Single pulse on line 2 with all lines enabled
        step(4'b0000, 1'b1, 4'b1111, 1'b0);
        step(4'b0100, 1'b0, 4'b0000, 1'b0);
        chk("s1_pending_e0", 32'(pending), 32'h4);
        chk("s1_noint_e0",   32'(interrupt), 32'd0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0);
        chk("s1_int_e1",  32'(interrupt), 32'd1);
        chk("s1_addr",    32'(int_addr),  32'hF8);
        step(4'b0000, 1'b0, 4'b0000, 1'b0);
        chk("s1_int_e2",  32'(interrupt), 32'd0);
        chk("s1_busy_e2", 32'(busy),      32'd1);
        step(4'b0000, 1'b0, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0);
        chk("s1_busy_hold", 32'(busy), 32'd1);
        step(4'b0000, 1'b0, 4'b0000, 1'b1);
        chk("s1_busy_rti", 32'(busy),     32'd0);
        chk("s1_addr_kept", 32'(int_addr), 32'hF8);

        // Lines 1 and 3 together: line 1 first, line 3 after rti
        step(4'b1010, 1'b0, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0);
        chk("s2_addr_first", 32'(int_addr), 32'hF4);
        chk("s2_pend_mid",   32'(pending),  32'h8);
        step(4'b0000, 1'b0, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b1);
        chk("s2_pend_idle", 32'(pending), 32'h8);
        step(4'b0000, 1'b0, 4'b0000, 1'b0);
        chk("s2_int_second",  32'(interrupt), 32'd1);
        chk("s2_addr_second", 32'(int_addr),  32'hFC);
        step(4'b0000, 1'b0, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b1);

        // Masked line keeps its pending bit; unmask delivers it
        step(4'b0000, 1'b1, 4'b0000, 1'b0);
        step(4'b0001, 1'b0, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0);
        chk("s3_masked_pend",  32'(pending),   32'h1);
        chk("s3_masked_noint", 32'(busy),      32'd0);
        step(4'b0000, 1'b1, 4'b0001, 1'b0);
        chk("s3_mask_edge_noint", 32'(interrupt), 32'd0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0);
        chk("s3_unmask_int",  32'(interrupt), 32'd1);
        chk("s3_unmask_addr", 32'(int_addr),  32'hF0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b1);

        // Line 0 edge during service of line 2 waits for rti
        step(4'b0000, 1'b1, 4'b1111, 1'b0);
        step(4'b0100, 1'b0, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0);
        step(4'b0001, 1'b0, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0);
        chk("s4_no_nest", 32'(interrupt), 32'd0);
        chk("s4_pend0",   32'(pending),   32'h1);
        step(4'b0000, 1'b0, 4'b0000, 1'b1);
        chk("s4_idle_noint", 32'(interrupt), 32'd0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0);
        chk("s4_line0_int",  32'(interrupt), 32'd1);
        chk("s4_line0_addr", 32'(int_addr),  32'hF0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b1);

        // rti in IDLE is ignored; a held level yields exactly one request
        step(4'b0000, 1'b0, 4'b0000, 1'b1);
        step(4'b0000, 1'b0, 4'b0000, 1'b1);
        chk("s5_rti_idle_busy", 32'(busy), 32'd0);
        n_int = 0;
        for (int k = 0; k < 10; k++) step(4'b1000, 1'b0, 4'b0000, 1'b0);
        step(4'b1000, 1'b0, 4'b0000, 1'b1);
        for (int k = 0; k < 4; k++) step(4'b1000, 1'b0, 4'b0000, 1'b0);
        chk("s5_single_int", 32'(n_int), 32'd1);
        step(4'b0000, 1'b0, 4'b0000, 1'b0);

        // Reset during service with line 2 pending; nothing replays afterwards
        step(4'b0010, 1'b0, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0);
        step(4'b0100, 1'b0, 4'b0000, 1'b0);
        step(4'b0100, 1'b0, 4'b0000, 1'b0);
        chk("s6_pend_before", 32'(pending), 32'h4);
        chk("s6_busy_before", 32'(busy),    32'd1);
        do_reset();
        n_int = 0;
        step(4'b0100, 1'b1, 4'b1111, 1'b0);
        for (int k = 0; k < 5; k++) step(4'b0100, 1'b0, 4'b0000, 1'b0);
        chk("s6_no_replay", 32'(n_int), 32'd0);

        // Randomized traffic against the model
        cur_irq = 4'b0100;
        for (int k = 0; k < 400; k++) begin
            r = $urandom;
            cur_irq = cur_irq ^ (r[3:0] & r[7:4]);
            step(cur_irq, (r[11:8] == 4'd0), r[15:12], r[17:16] == 2'd0);
            if (k == 200) begin
                do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 4, meaning the number of interrupt request lines.
REQ-002 SHALL have parameter VEC_BASE, default 8'hF0, meaning the handler address for line 0.
REQ-003 SHALL have parameter VEC_STRIDE, default 4, meaning the address spacing between handler vectors.
REQ-004 SHALL have port clk  in  1  clock; all state is updated on its rising edge.
REQ-005 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port irq  in  NUM_IRQ  level request lines, already synchronous to clk.
REQ-007 SHALL have port mask_we  in  1  write strobe for the mask register.
REQ-008 SHALL have port mask_wdata  in  NUM_IRQ  new mask value; bit=1 enables the line.
REQ-009 SHALL have port rti  in  1  return-from-interrupt pulse from the program counter or decoder.
REQ-010 SHALL have port interrupt  out  1  one-cycle request to the program counter to jump.
REQ-011 SHALL have port int_addr  out  8  handler address, valid while interrupt=1.
REQ-012 SHALL have port busy  out  1  high while a handler is in service.
REQ-013 SHALL have port pending  out  NUM_IRQ  latched, undelivered requests.

Function
REQ-014 SHALL register irq into irq_q each cycle and define edge[i] = irq[i] & ~irq_q[i].
REQ-015 SHALL set pending[i] on the clock edge at which edge[i]=1.
REQ-016 SHALL clear pending[i] on the clock edge at which line i is granted.
REQ-017 SHALL keep pending[i] set when edge[i] and a grant of line i coincide, because the new edge wins.
REQ-018 SHALL update mask from mask_wdata on the clock edge where mask_we=1; the new mask affects arbitration from the next cycle.
REQ-019 SHALL retain pending bits of masked lines, so a later unmask delivers them.
REQ-020 SHALL arbitrate only over (pending & mask), with fixed priority: line 0 highest.
REQ-021 SHALL implement states IDLE, ASSERT and SERVICE.
REQ-022 SHALL transition IDLE->ASSERT when (pending & mask) != 0, latching the winning index and clearing its pending bit on the same edge.
REQ-023 SHALL transition ASSERT->SERVICE unconditionally after exactly one cycle.
REQ-024 SHALL transition SERVICE->IDLE on the edge where rti=1.
REQ-025 SHALL drive interrupt=1 only in ASSERT, so it is exactly one cycle wide.
REQ-026 SHALL set int_addr = VEC_BASE + index*VEC_STRIDE, computed modulo 256 in 8 bits.
REQ-027 SHALL hold int_addr stable from ASSERT through SERVICE, and SHALL keep the last value while in IDLE.
REQ-028 SHALL drive busy=1 in ASSERT and SERVICE, and busy=0 in IDLE.
REQ-029 SHALL ignore rti in IDLE and in ASSERT.
REQ-030 SHALL have no nesting: edges arriving during ASSERT or SERVICE only set pending.
REQ-031 SHALL deliver the next request no earlier than the cycle after return to IDLE.
REQ-032 SHALL have this latency: irq[i] rises and is first sampled at edge E0, pending[i]=1 after E0, interrupt=1 after E1, and the state is SERVICE after E2.
REQ-033 SHALL not re-trigger on a level held high; each rising edge produces one request.

Reset
REQ-034 SHALL, on reset, asynchronously force state=IDLE, irq_q=0, pending=0, mask=0 (all lines disabled), int_addr=0, interrupt=0 and busy=0.
REQ-035 SHALL, on reset mid-ASSERT or mid-SERVICE, abandon the in-service request without a later replay.
REQ-036 SHALL, after reset deassertion, not report an irq line already high as an edge until that line falls and rises again.

Structure
REQ-037 SHALL place the state encoding (IDLE/ASSERT/SERVICE), NUM_IRQ, VEC_BASE and VEC_STRIDE defaults in the shared processor package.
REQ-038 SHALL use one sub-module, irq_priority_encoder, which is combinational and maps (pending & mask) to a valid flag and an index.
REQ-039 SHALL keep all other logic in interrupt_controller.

Verification
REQ-040 SHALL cover this scenario: mask=4'b1111, pulse irq[2] -> interrupt for one cycle two clocks after sampling, int_addr=8'hF8, busy=1 until rti.
REQ-041 SHALL cover this scenario: irq[1] and irq[3] rise together -> first int_addr=8'hF4; after rti, int_addr=8'hFC, with pending=4'b1000 in between.
REQ-042 SHALL cover this scenario: mask=4'b0000, irq[0] edge -> no interrupt and pending=4'b0001; write mask=4'b0001 -> interrupt with int_addr=8'hF0.
REQ-043 SHALL cover this scenario: irq[0] edge during SERVICE of line 2 -> no interrupt until rti; the line 0 interrupt follows the cycle after IDLE is re-entered.
REQ-044 SHALL cover this scenario: rti pulsed in IDLE, and irq held high for 10 cycles -> no interrupt beyond the single one caused by the edge.
REQ-045 SHALL cover this scenario: assert reset during SERVICE with pending=4'b0100 -> all outputs 0, pending=0, and no interrupt after release.
